// File: rtl/ccff_pkg.sv
// Shared constants and FSM state encoding for the configuration-chain loader.
package ccff_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 64;
  localparam int unsigned WORD_W_DEFAULT    = 32;

  typedef logic [2:0] ccff_state_t;

  localparam ccff_state_t StIdle  = 3'd0;
  localparam ccff_state_t StLoad  = 3'd1;
  localparam ccff_state_t StShift = 3'd2;
  localparam ccff_state_t StDone  = 3'd3;
  localparam ccff_state_t StErr   = 3'd4;

endpackage

// File: rtl/ccff_loader_if.sv
// Host configuration word stream (valid/ready) feeding the ccff loader.
interface ccff_loader_if
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );

endinterface

// File: rtl/ccff_piso.sv
// Parallel-load, serial-out shift register; bit 0 leaves first, shifting right.
module ccff_piso #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              serial
);

  logic [WORD_W-1:0] sreg_q;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= data;
    end else if (shift) begin
      sreg_q <= sreg_q >> 1;
    end
  end

  assign serial = sreg_q[0];

endmodule

// File: rtl/ccff_loader.sv
// Streams host configuration words LSB-first into a CHAIN_LEN-long ccff chain,
// checking that the stream length exactly matches the chain.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         start,
  ccff_loader_if.slave cfg,
  output logic         ccff_head,
  output logic         ccff_shift_en,
  output logic         IO_ISOL_N,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int unsigned BitCntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordCntW = $clog2(WORD_W + 1);
  localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(CHAIN_LEN - 1);
  localparam logic [WordCntW-1:0] WordLast = WordCntW'(WORD_W - 1);

  ccff_state_t         state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
  logic                last_q, last_d;
  logic                accept;
  logic                chain_full;
  logic                piso_out;

  assign accept     = (state_q == StLoad) && cfg.cfg_valid;
  // This shift is the one that makes the chain complete.
  assign chain_full = (bit_cnt_q == BitLast);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    last_d     = last_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d   = StLoad;
          bit_cnt_d = '0;
        end
      end
      StLoad: begin
        if (cfg.cfg_valid) begin
          state_d    = StShift;
          word_cnt_d = '0;
          last_d     = cfg.cfg_last;
        end
      end
      StShift: begin
        bit_cnt_d  = bit_cnt_q + BitCntW'(1);
        word_cnt_d = word_cnt_q + WordCntW'(1);
        if (chain_full) begin
          state_d = last_q ? StDone : StErr;
        end else if (word_cnt_q == WordLast) begin
          state_d = last_q ? StErr : StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      last_q     <= last_d;
    end
  end

  ccff_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .load      (accept),
    .shift     (ccff_shift_en),
    .data      (cfg.cfg_data),
    .serial    (piso_out)
  );

  assign cfg.cfg_ready  = (state_q == StLoad);
  assign ccff_shift_en  = (state_q == StShift);
  assign ccff_head      = ccff_shift_en & piso_out;
  // I/O stays isolated until a complete, length-checked pass has landed.
  assign IO_ISOL_N      = (state_q == StDone);
  assign busy           = (state_q == StLoad) || (state_q == StShift);
  assign done           = (state_q == StDone);
  assign error          = (state_q == StErr);

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the downstream ccff chain (>=1).
REQ-002 SHALL have parameter WORD_W, default 32: width of the host configuration word.
REQ-003 SHALL have ports: prog_clk  in  1  programming clock, the only clock; prog_reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  single-cycle request to begin a programming pass.
REQ-005 SHALL have ports: cfg_valid  in  1 / cfg_ready  out  1 / cfg_data  in  WORD_W / cfg_last  in  1  host word stream, valid/ready.
REQ-006 SHALL have ports: ccff_head  out  1  serial bit into the chain; ccff_shift_en  out  1  chain clock-enable, shift on a prog_clk edge where high.
REQ-007 SHALL have ports: IO_ISOL_N  out  1  I/O isolation to all grid_io tiles, low isolates.
REQ-008 SHALL have ports: busy, done, error  out  1 each  status.

Function
REQ-009 SHALL implement FSM IDLE, LOAD, SHIFT, DONE, ERR with registered state.
REQ-010 IDLE/DONE/ERR: start=1 -> LOAD next cycle; clear bit counter; clear done/error.
REQ-011 LOAD: cfg_ready=1; a word is accepted when cfg_valid and cfg_ready are both high; the accepted word is loaded into the shift register; go to SHIFT next cycle.
REQ-012 SHIFT: ccff_shift_en=1 and ccff_head=shift_reg[0] each cycle; shift register shifts right; bit counter +1. Bit order is LSB first, so word 0 bit 0 enters the chain first.
REQ-013 SHIFT exits after WORD_W bits of the current word, or when the total count reaches CHAIN_LEN, whichever is first.
REQ-014 On the SHIFT exit with total < CHAIN_LEN: word carried cfg_last=1 -> ERR (short stream); otherwise -> LOAD.
REQ-015 On the SHIFT exit with total = CHAIN_LEN: word carried cfg_last=1 -> DONE; otherwise -> ERR (long stream). Surplus high bits of the final word are discarded, never shifted.
REQ-016 ccff_shift_en SHALL be 0 in every state except SHIFT, so the chain holds while the host stalls; ccff_head=0 outside SHIFT.
REQ-017 cfg_ready SHALL be 0 outside LOAD; words offered outside LOAD are not consumed.
REQ-018 IO_ISOL_N SHALL be 0 from the cycle after start is accepted until DONE, high in DONE; 0 in ERR; unchanged in IDLE (reset value 0).
REQ-019 busy=1 in LOAD/SHIFT; done=1 in DONE; error=1 in ERR.
REQ-020 start SHALL be ignored while busy.
REQ-021 Latency: word accepted in cycle t -> its bits shifted in cycles t+1 .. t+n; LOAD again at t+n+1 (one bubble per word).
REQ-022 The bit counter width SHALL be clog2(CHAIN_LEN+1); the per-word counter width SHALL be clog2(WORD_W+1); no wrap is permitted.

Reset
REQ-023 prog_reset=1 SHALL asynchronously force IDLE, clear counters and the shift register, and drive ccff_shift_en=0, ccff_head=0, cfg_ready=0, IO_ISOL_N=0, busy=0, done=0, error=0.
REQ-024 Reset mid-pass SHALL abort the pass; chain contents are then undefined, and isolation holds until a complete pass reaches DONE.

Structure
REQ-025 The FSM state enum and the default CHAIN_LEN/WORD_W constants SHALL live in the shared package ccff_pkg.
REQ-026 One sub-module ccff_piso (WORD_W-bit parallel-load, serial-out shift register with load/shift enables) SHALL be used; the FSM and counters remain in ccff_loader.

Verification
REQ-027 CHAIN_LEN=40, WORD_W=32; words 0xA5A5A5A5 then 0x000000C3 with last, back-to-back -> 40 shift_en pulses in cycles 2..33 and 35..42; done=1 and IO_ISOL_N=1 at cycle 43; model chain equals the expected 40 bits.
REQ-028 Same setup, cfg_valid dropped for 10 cycles between the two words -> shift_en=0 throughout the gap, final chain contents identical to REQ-027.
REQ-029 CHAIN_LEN=64, cfg_last on word 0 -> error=1 after 32 shifts, IO_ISOL_N=0, no further cfg_ready.
REQ-030 CHAIN_LEN=32, word 0 without last -> error=1 after 32 shifts.
REQ-031 prog_reset pulsed during shifting of word 1 -> all outputs reach reset values within the same cycle; a new start then completes a full pass to done=1.
REQ-032 start pulsed during SHIFT -> ignored, shift count unaffected.
